// File: rtl/mem_resp_pkg.sv
// rtl/mem_resp_pkg.sv - shared types and helpers for the mem_responder slice
//
// Purpose : access-size and FSM state enums, byte-count helper.
// Ports   : none (package).
package mem_resp_pkg;

   typedef enum logic [1:0] {
      SIZE_B = 2'b00,
      SIZE_H = 2'b01,
      SIZE_W = 2'b10,
      SIZE_D = 2'b11
   } size_e;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      BUSY = 2'b01,
      RESP = 2'b10
   } state_e;

   // Number of bytes moved by an access of the given size (1, 2, 4 or 8).
   function automatic logic [3:0] size_bytes(input size_e i_size);
      return 4'd1 << i_size;
   endfunction

endpackage

// File: rtl/mem_resp_lane_mask.sv
// rtl/mem_resp_lane_mask.sv - byte-enable and misalignment decode for one access
//
// Purpose : turns access size and byte offset into the 8-bit lane enable used
//           by both the store merge and the load extract, and flags offsets
//           that are not a multiple of the access size.
// Ports   : i_size       access size (byte/half/word/double)
//           i_offset     byte offset within the 64-bit word
//           o_byte_en    lanes touched; lanes past byte 7 fall off the top
//           o_misaligned offset not a multiple of the access size
module mem_resp_lane_mask
   import mem_resp_pkg::*;
(
   input  size_e       i_size,
   input  logic [2:0]  i_offset,
   output logic [7:0]  o_byte_en,
   output logic        o_misaligned
);

   logic [7:0] w_base;

   always_comb begin
      w_base = 8'h01;
      case (i_size)
         SIZE_B:  w_base = 8'h01;
         SIZE_H:  w_base = 8'h03;
         SIZE_W:  w_base = 8'h0F;
         SIZE_D:  w_base = 8'hFF;
         default: w_base = 8'h01;
      endcase
   end

   // 8-bit shift deliberately truncates lanes that cross the word boundary.
   assign o_byte_en    = w_base << i_offset;
   assign o_misaligned = (({1'b0, i_offset} & (size_bytes(i_size) - 4'd1)) != 4'd0);

endmodule

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - multicycle load/store memory target with fixed latency
//
// Purpose : single-outstanding memory responder. A request accepted in IDLE
//           is held for READ_LATENCY cycles, executed against a 64-bit-wide
//           storage array, and its response is held until handshaken.
// Ports   : clk, arstn                  clock, async active-low reset
//           i_req_valid / o_req_ready   request handshake
//           i_req_write, i_req_size     store flag, access size
//           i_req_addr, i_req_wdata     byte address, right-aligned store data
//           o_rsp_valid / i_rsp_ready   response handshake
//           o_rsp_rdata, o_rsp_error    right-aligned load data, reject flag
// Config  : MEM_RESP_MISALIGN_CHECK_EN - when defined, accesses whose offset is
//           not a multiple of their size are rejected.
module mem_responder
   import mem_resp_pkg::*;
#(
   parameter int ADDR_WIDTH   = 64,
   parameter int DATA_WIDTH   = 64,
   parameter int DEPTH_WORDS  = 1024,
   parameter int READ_LATENCY = 2
) (
   input  logic                  clk,
   input  logic                  arstn,
   input  logic                  i_req_valid,
   output logic                  o_req_ready,
   input  logic                  i_req_write,
   input  logic [1:0]            i_req_size,
   input  logic [ADDR_WIDTH-1:0] i_req_addr,
   input  logic [DATA_WIDTH-1:0] i_req_wdata,
   output logic                  o_rsp_valid,
   input  logic                  i_rsp_ready,
   output logic [DATA_WIDTH-1:0] o_rsp_rdata,
   output logic                  o_rsp_error
);

   localparam int IDX_W = $clog2(DEPTH_WORDS);
   localparam int CNT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(READ_LATENCY - 1);

`ifdef MEM_RESP_MISALIGN_CHECK_EN
   localparam logic MISALIGN_CHECK = 1'b1;
`else
   localparam logic MISALIGN_CHECK = 1'b0;
`endif

   state_e                r_state;
   state_e                w_state_next;
   logic [CNT_W-1:0]      r_cnt;
   logic                  r_write;
   size_e                 r_size;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [DATA_WIDTH-1:0] r_wdata;
   logic [DATA_WIDTH-1:0] r_rdata;
   logic                  r_error;

   logic [DATA_WIDTH-1:0] r_mem [DEPTH_WORDS];

   logic                  w_accept;
   logic                  w_execute;
   logic [IDX_W-1:0]      w_idx;
   logic [2:0]            w_offset;
   logic                  w_out_of_range;
   logic                  w_misaligned;
   logic                  w_reject;
   logic [7:0]            w_byte_en;
   logic [DATA_WIDTH-1:0] w_bit_mask;
   logic [DATA_WIDTH-1:0] w_word;
   logic [DATA_WIDTH-1:0] w_wdata_shift;
   logic [DATA_WIDTH-1:0] w_rdata_load;

   // Everything downstream of accept works from the captured request, so
   // input changes after accept cannot disturb the access.
   assign w_idx          = r_addr[3 +: IDX_W];
   assign w_offset       = r_addr[2:0];
   assign w_out_of_range = |r_addr[ADDR_WIDTH-1:3+IDX_W];
   assign w_reject       = w_out_of_range | (MISALIGN_CHECK & w_misaligned);

   mem_resp_lane_mask u_lane_mask (
      .i_size       (r_size),
      .i_offset     (w_offset),
      .o_byte_en    (w_byte_en),
      .o_misaligned (w_misaligned)
   );

   always_comb begin
      w_bit_mask = '0;
      for (int i = 0; i < 8; i++) begin
         w_bit_mask[8*i +: 8] = {8{w_byte_en[i]}};
      end
   end

   assign w_word        = r_mem[w_idx];
   assign w_wdata_shift = r_wdata << {w_offset, 3'b000};
   // Masking before the shift equals shift-then-mask-to-size, and lanes that
   // crossed the word boundary are already absent from the enable.
   assign w_rdata_load  = (w_word & w_bit_mask) >> {w_offset, 3'b000};

   // FSM state register.
   always_ff @(posedge clk or negedge arstn) begin
      if (!arstn) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // FSM next state and handshake outputs.
   always_comb begin
      w_state_next = r_state;
      o_req_ready  = 1'b0;
      o_rsp_valid  = 1'b0;
      w_accept     = 1'b0;
      w_execute    = 1'b0;
      case (r_state)
         IDLE: begin
            o_req_ready = 1'b1;
            if (i_req_valid) begin
               w_accept     = 1'b1;
               w_state_next = BUSY;
            end
         end
         BUSY: begin
            if (r_cnt == '0) begin
               w_execute    = 1'b1;
               w_state_next = RESP;
            end
         end
         RESP: begin
            o_rsp_valid = 1'b1;
            if (i_rsp_ready) begin
               w_state_next = IDLE;
            end
         end
         default: w_state_next = IDLE;
      endcase
   end

   // Request capture, latency counter and response registers.
   always_ff @(posedge clk or negedge arstn) begin
      if (!arstn) begin
         r_cnt   <= '0;
         r_write <= 1'b0;
         r_size  <= SIZE_B;
         r_addr  <= '0;
         r_wdata <= '0;
         r_rdata <= '0;
         r_error <= 1'b0;
      end else begin
         if (w_accept) begin
            r_cnt   <= CNT_INIT;
            r_write <= i_req_write;
            r_size  <= size_e'(i_req_size);
            r_addr  <= i_req_addr;
            r_wdata <= i_req_wdata;
         end else if (r_state == BUSY && !w_execute) begin
            r_cnt <= r_cnt - 1'b1;
         end
         if (w_execute) begin
            r_rdata <= (w_reject || r_write) ? '0 : w_rdata_load;
            r_error <= w_reject;
         end
      end
   end

   // Storage has no reset. A reset during BUSY forces the FSM to IDLE
   // asynchronously, so w_execute cannot fire and a pending store is dropped.
   always_ff @(posedge clk) begin
      if (w_execute && r_write && !w_reject) begin
         for (int i = 0; i < 8; i++) begin
            if (w_byte_en[i]) begin
               r_mem[w_idx][8*i +: 8] <= w_wdata_shift[8*i +: 8];
            end
         end
      end
   end

   assign o_rsp_rdata = r_rdata;
   assign o_rsp_error = r_error;

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - scoreboard bench for mem_responder
module tb_mem_responder;

   localparam int RL = 2;

   logic        clk = 1'b0;
   logic        arstn;
   logic        i_req_valid;
   logic        o_req_ready;
   logic        i_req_write;
   logic [1:0]  i_req_size;
   logic [63:0] i_req_addr;
   logic [63:0] i_req_wdata;
   logic        o_rsp_valid;
   logic        i_rsp_ready;
   logic [63:0] o_rsp_rdata;
   logic        o_rsp_error;

   typedef struct packed {
      logic [63:0] rdata;
      logic        err;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   mem_responder #(
      .ADDR_WIDTH   (64),
      .DATA_WIDTH   (64),
      .DEPTH_WORDS  (1024),
      .READ_LATENCY (RL)
   ) dut (
      .clk         (clk),
      .arstn       (arstn),
      .i_req_valid (i_req_valid),
      .o_req_ready (o_req_ready),
      .i_req_write (i_req_write),
      .i_req_size  (i_req_size),
      .i_req_addr  (i_req_addr),
      .i_req_wdata (i_req_wdata),
      .o_rsp_valid (o_rsp_valid),
      .i_rsp_ready (i_rsp_ready),
      .o_rsp_rdata (o_rsp_rdata),
      .o_rsp_error (o_rsp_error)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // One full request/response transaction; hold > 0 stalls the response
   // handshake and fires a stray request meanwhile.
   task automatic access(input logic wr, input logic [1:0] sz, input logic [63:0] addr,
                         input logic [63:0] wdata, input logic [63:0] exp_rdata,
                         input logic exp_err, input int hold);
      int          cyc;
      exp_t        e;
      logic [63:0] held;
      @(negedge clk);
      check("req_ready_idle", {63'd0, o_req_ready}, 64'd1);
      i_req_valid = 1'b1;
      i_req_write = wr;
      i_req_size  = sz;
      i_req_addr  = addr;
      i_req_wdata = wdata;
      sb.push_back('{rdata: exp_rdata, err: exp_err});
      @(posedge clk);
      @(negedge clk);
      i_req_valid = 1'b0;
      i_req_write = ~wr;
      i_req_size  = ~sz;
      i_req_addr  = addr ^ 64'h8;
      i_req_wdata = ~wdata;
      cyc = 0;
      while (!o_rsp_valid && cyc < 20) begin
         @(negedge clk);
         cyc++;
      end
      check("rsp_latency", 64'(cyc), 64'(RL));
      check("req_ready_resp", {63'd0, o_req_ready}, 64'd0);
      if (sb.size() == 0) begin
         check("sb_underflow", 64'(sb.size()), 64'd1);
      end else begin
         e = sb.pop_front();
         check("rsp_rdata", o_rsp_rdata, e.rdata);
         check("rsp_error", {63'd0, o_rsp_error}, {63'd0, e.err});
      end
      held = o_rsp_rdata;
      for (int i = 0; i < hold; i++) begin
         i_req_valid = (i == 2);
         i_req_write = 1'b1;
         i_req_size  = 2'b11;
         i_req_addr  = addr;
         i_req_wdata = 64'd0;
         @(negedge clk);
         check("hold_valid", {63'd0, o_rsp_valid}, 64'd1);
         check("hold_rdata", o_rsp_rdata, held);
         check("hold_ready", {63'd0, o_req_ready}, 64'd0);
      end
      i_req_valid = 1'b0;
      i_rsp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      i_rsp_ready = 1'b0;
      check("post_ready", {63'd0, o_req_ready}, 64'd1);
      check("post_valid", {63'd0, o_rsp_valid}, 64'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      arstn       = 1'b0;
      i_req_valid = 1'b0;
      i_req_write = 1'b0;
      i_req_size  = 2'b00;
      i_req_addr  = 64'd0;
      i_req_wdata = 64'd0;
      i_rsp_ready = 1'b0;
      #1;
      check("rst_ready", {63'd0, o_req_ready}, 64'd1);
      check("rst_valid", {63'd0, o_rsp_valid}, 64'd0);
      check("rst_rdata", o_rsp_rdata, 64'd0);
      check("rst_error", {63'd0, o_rsp_error}, 64'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      arstn = 1'b1;

      access(1'b1, 2'b11, 64'h0,  64'h0123456789ABCDEF, 64'd0, 1'b0, 0);
      access(1'b1, 2'b11, 64'h10, 64'h1122334455667788, 64'd0, 1'b0, 0);
      access(1'b0, 2'b11, 64'h10, 64'd0, 64'h1122334455667788, 1'b0, 0);
      access(1'b1, 2'b00, 64'h13, 64'hFFFFFFFFFFFFFFAB, 64'd0, 1'b0, 0);
      access(1'b0, 2'b11, 64'h10, 64'd0, 64'h11223344AB667788, 1'b0, 0);
      access(1'b0, 2'b01, 64'h12, 64'd0, 64'h000000000000AB66, 1'b0, 0);
      access(1'b0, 2'b11, 64'h10, 64'd0, 64'h11223344AB667788, 1'b0, 5);

      // Reset while a store sits in BUSY.
      @(negedge clk);
      i_req_valid = 1'b1;
      i_req_write = 1'b1;
      i_req_size  = 2'b11;
      i_req_addr  = 64'h10;
      i_req_wdata = 64'hDEAD;
      @(posedge clk);
      @(negedge clk);
      i_req_valid = 1'b0;
      check("busy_ready", {63'd0, o_req_ready}, 64'd0);
      arstn = 1'b0;
      #1;
      check("arst_ready", {63'd0, o_req_ready}, 64'd1);
      check("arst_valid", {63'd0, o_rsp_valid}, 64'd0);
      check("arst_rdata", o_rsp_rdata, 64'd0);
      check("arst_error", {63'd0, o_rsp_error}, 64'd0);
      @(negedge clk);
      arstn = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("arst_no_rsp", {63'd0, o_rsp_valid}, 64'd0);
      end
      access(1'b0, 2'b11, 64'h10, 64'd0, 64'h11223344AB667788, 1'b0, 0);

      access(1'b0, 2'b11, 64'h2000, 64'd0, 64'd0, 1'b1, 0);
      access(1'b1, 2'b00, 64'h2000, 64'hFF, 64'd0, 1'b1, 0);
      access(1'b0, 2'b11, 64'h0, 64'd0, 64'h0123456789ABCDEF, 1'b0, 0);

`ifdef MEM_RESP_MISALIGN_CHECK_EN
      access(1'b0, 2'b10, 64'h12, 64'd0, 64'd0, 1'b1, 0);
      access(1'b1, 2'b01, 64'h17, 64'hBEEF, 64'd0, 1'b1, 0);
      access(1'b0, 2'b11, 64'h10, 64'd0, 64'h11223344AB667788, 1'b0, 0);
`else
      access(1'b0, 2'b10, 64'h12, 64'd0, 64'h000000003344AB66, 1'b0, 0);
      access(1'b1, 2'b01, 64'h17, 64'hBEEF, 64'd0, 1'b0, 0);
      access(1'b0, 2'b11, 64'h10, 64'd0, 64'hEF223344AB667788, 1'b0, 0);
`endif

      check("sb_empty", 64'(sb.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
